// File: rtl/io_rgb_pwm.sv
// IO-mapped three-channel PWM LED controller with double-buffered duty registers.
// Duty changes take effect only at a PWM period boundary, or at once on a FORCE write.
module io_rgb_pwm #(
  parameter logic [7:0] BASE_ADDR = 8'h20,
  parameter logic [7:0] PRESC_RST = 8'd0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] io_addr_i,
  input  logic [7:0] io_data_i,
  input  logic       io_write_i,
  input  logic       io_read_i,
  output logic [7:0] io_data_o,
  output logic [2:0] led_o
);

  logic            en_q, en_d;
  logic            inv_q, inv_d;
  logic [7:0]      presc_q, presc_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [2:0][7:0] active_q, active_d;
  logic            pend_q, pend_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      presc_cnt_q, presc_cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic [2:0]      led_q, led_d;

  logic [7:0] off;
  logic       in_range;
  logic       wr_en;
  logic       rd_en;
  logic       tick;
  logic       boundary;
  logic [2:0] pwm;

  assign off      = io_addr_i - BASE_ADDR;
  assign in_range = (off < 8'd7);
  assign wr_en    = io_write_i && in_range;
  assign rd_en    = io_read_i && in_range;
  assign tick     = en_q && (presc_cnt_q == presc_q);
  assign boundary = tick && (cnt_q == 8'hff);

  always_comb begin
    en_d        = en_q;
    inv_d       = inv_q;
    presc_d     = presc_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    presc_cnt_d = presc_cnt_q;
    rdata_d     = rdata_q;

    // The >= also pulls presc_cnt back to 0 after PRESC is written below its current value.
    if (en_q) begin
      presc_cnt_d = (presc_cnt_q >= presc_q) ? 8'd0 : presc_cnt_q + 8'd1;
      if (tick) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      presc_cnt_d = 8'd0;
      cnt_d       = 8'd0;
    end

    if (boundary && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end

    if (wr_en) begin
      case (off)
        8'd0: begin
          en_d  = io_data_i[0];
          inv_d = io_data_i[1];
        end
        8'd1:    presc_d = io_data_i;
        default: ;
      endcase
      // A duty write on a boundary clock still sets PEND; active took the old shadow above.
      for (int i = 0; i < 3; i++) begin
        if (off == 8'(i + 2)) begin
          shadow_d[i] = io_data_i;
          if (en_q) begin
            pend_d = 1'b1;
          end else begin
            active_d[i] = io_data_i;
          end
        end
      end
      if ((off == 8'd0) && io_data_i[2]) begin
        active_d = shadow_q;
        pend_d   = 1'b0;
      end
    end

    if (rd_en) begin
      case (off)
        8'd0:    rdata_d = {6'd0, inv_q, en_q};
        8'd1:    rdata_d = presc_q;
        8'd2:    rdata_d = shadow_q[0];
        8'd3:    rdata_d = shadow_q[1];
        8'd4:    rdata_d = shadow_q[2];
        8'd5:    rdata_d = {7'd0, pend_q};
        8'd6:    rdata_d = cnt_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < 3; i++) begin
      pwm[i] = (cnt_q < active_q[i]);
    end
    led_d = en_q ? (pwm ^ {3{inv_q}}) : {3{inv_q}};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      en_q        <= 1'b0;
      inv_q       <= 1'b0;
      presc_q     <= PRESC_RST;
      shadow_q    <= '0;
      active_q    <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= 8'd0;
      presc_cnt_q <= 8'd0;
      rdata_q     <= 8'd0;
      led_q       <= 3'b000;
    end else begin
      en_q        <= en_d;
      inv_q       <= inv_d;
      presc_q     <= presc_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      presc_cnt_q <= presc_cnt_d;
      rdata_q     <= rdata_d;
      led_q       <= led_d;
    end
  end

  assign io_data_o = rdata_q;
  assign led_o     = led_q;

endmodule

// File: tb/tb_io_rgb_pwm.sv
// Self-checking bench for io_rgb_pwm: register table, PWM waveform windows, boundary/FORCE/reset.
module tb_io_rgb_pwm;

  localparam logic [7:0] B     = 8'h20;
  localparam logic [7:0] PRST  = 8'h07;
  localparam logic [7:0] A_CTL = B;
  localparam logic [7:0] A_PRE = B + 8'd1;
  localparam logic [7:0] A_R   = B + 8'd2;
  localparam logic [7:0] A_G   = B + 8'd3;
  localparam logic [7:0] A_B   = B + 8'd4;
  localparam logic [7:0] A_ST  = B + 8'd5;
  localparam logic [7:0] A_CNT = B + 8'd6;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] io_addr_i;
  logic [7:0] io_data_i;
  logic       io_write_i;
  logic       io_read_i;
  logic [7:0] io_data_o;
  logic [2:0] led_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[27];
  sb_t  sb[$];

  io_rgb_pwm #(
    .BASE_ADDR(B),
    .PRESC_RST(PRST)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .io_addr_i (io_addr_i),
    .io_data_i (io_data_i),
    .io_write_i(io_write_i),
    .io_read_i (io_read_i),
    .io_data_o (io_data_o),
    .led_o     (led_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns 1 time unit after edge number n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic bus_cycle(input logic wr, input logic rd, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] exp, input string name);
    sb_t e;
    io_write_i = wr;
    io_read_i  = rd;
    io_addr_i  = addr;
    io_data_i  = data;
    if (rd) sb.push_back('{name, exp});
    @(posedge clk_i);
    #1;
    io_write_i = 1'b0;
    io_read_i  = 1'b0;
    if (rd) begin
      e = sb.pop_front();
      check(e.name, io_data_o, e.exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, a, d, 8'h00, "");
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus_cycle(1'b0, 1'b1, a, 8'h00, exp, name);
  endtask

  // Compares led_o after edges first..last; counter started from 0 at edge ep with EN=1.
  task automatic measure(input logic [7:0] dr, input logic [7:0] dg, input logic [7:0] db,
                         input int presc, input logic inv, input int ep, input int first,
                         input int last, input string name);
    int         bad;
    int         c;
    logic [2:0] exp;
    bad = 0;
    for (int m = first; m <= last; m++) begin
      wait_edge(m);
      c   = ((m - 1 - ep) / (presc + 1)) % 256;
      exp = {c < int'(db), c < int'(dg), c < int'(dr)} ^ {3{inv}};
      if (led_o !== exp) bad++;
    end
    check(name, bad, 0);
  endtask

  initial begin
    int e0;
    rst_i      = 1'b0;
    io_addr_i  = 8'h00;
    io_data_i  = 8'h00;
    io_write_i = 1'b0;
    io_read_i  = 1'b0;

    tbl = '{
      '{1'b0, 1'b1, A_CTL, 8'h00, 8'h00}, '{1'b0, 1'b1, A_PRE, 8'h00, PRST},
      '{1'b0, 1'b1, A_R, 8'h00, 8'h00},   '{1'b0, 1'b1, A_G, 8'h00, 8'h00},
      '{1'b0, 1'b1, A_B, 8'h00, 8'h00},   '{1'b0, 1'b1, A_ST, 8'h00, 8'h00},
      '{1'b0, 1'b1, A_CNT, 8'h00, 8'h00}, '{1'b1, 1'b0, A_PRE, 8'h5a, 8'h00},
      '{1'b0, 1'b1, A_PRE, 8'h00, 8'h5a}, '{1'b1, 1'b0, B + 8'd7, 8'hff, 8'h00},
      '{1'b1, 1'b0, B - 8'd1, 8'hff, 8'h00}, '{1'b0, 1'b1, B + 8'd7, 8'h00, 8'h5a},
      '{1'b0, 1'b1, B - 8'd1, 8'h00, 8'h5a}, '{1'b0, 1'b1, A_PRE, 8'h00, 8'h5a},
      '{1'b1, 1'b0, A_ST, 8'hff, 8'h00},  '{1'b1, 1'b0, A_CNT, 8'hff, 8'h00},
      '{1'b0, 1'b1, A_ST, 8'h00, 8'h00},  '{1'b0, 1'b1, A_CNT, 8'h00, 8'h00},
      '{1'b1, 1'b0, A_G, 8'h77, 8'h00},   '{1'b0, 1'b1, A_G, 8'h00, 8'h77},
      '{1'b0, 1'b1, A_ST, 8'h00, 8'h00},  '{1'b1, 1'b0, A_CTL, 8'h06, 8'h00},
      '{1'b0, 1'b1, A_CTL, 8'h00, 8'h02}, '{1'b1, 1'b0, A_CTL, 8'h00, 8'h00},
      '{1'b0, 1'b1, A_CTL, 8'h00, 8'h00}, '{1'b0, 1'b1, A_R, 8'h00, 8'h00},
      '{1'b0, 1'b1, A_B, 8'h00, 8'h00}
    };

    // Reset
    repeat (4) @(posedge clk_i);
    #1;
    check("rst_led", led_o, 3'b000);
    check("rst_rdata", io_data_o, 8'h00);
    rst_i = 1'b1;

    for (int i = 0; i < 27; i++) begin
      bus_cycle(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].data, tbl[i].exp,
                $sformatf("tbl%0d", i));
    end

    // Same-clock read and write of PRESC returns the old value
    bus_cycle(1'b1, 1'b1, A_PRE, 8'h33, 8'h5a, "rw_same_clk_old");
    rd(A_PRE, 8'h33, "rw_same_clk_new");
    wr(A_PRE, 8'h00);
    wr(A_G, 8'h00);

    // PRESC=0, R=64 loaded directly while disabled
    wr(A_R, 8'h40);
    wr(A_CTL, 8'h01);
    e0 = cyc;
    measure(8'h40, 8'h00, 8'h00, 0, 1'b0, e0, e0 + 1, e0 + 512, "pwm_r64");

    // PRESC=3, G=128, mid-period update to 32
    wr(A_CTL, 8'h00);
    wr(A_R, 8'h00);
    wr(A_G, 8'h80);
    wr(A_PRE, 8'h03);
    wr(A_CTL, 8'h01);
    e0 = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_edge(e0 + 4 * k);
      rd(A_CNT, 8'(k), $sformatf("cnt_step%0d", k));
    end
    measure(8'h00, 8'h80, 8'h00, 3, 1'b0, e0, e0 + 14, e0 + 399, "pwm_g128");
    wr(A_G, 8'h20);
    rd(A_ST, 8'h01, "pend_after_duty");
    rd(A_G, 8'h20, "shadow_g");
    measure(8'h00, 8'h80, 8'h00, 3, 1'b0, e0, e0 + 403, e0 + 1020, "pwm_g_held");
    rd(A_ST, 8'h01, "pend_before_wrap");
    wait_edge(e0 + 1024);
    rd(A_ST, 8'h00, "pend_after_wrap");
    measure(8'h00, 8'h20, 8'h00, 3, 1'b0, e0, e0 + 1026, e0 + 2048, "pwm_g32");

    // DUTY_B write on the exact boundary clock
    wait_edge(e0 + 2099);
    wr(A_B, 8'h40);
    wait_edge(e0 + 3071);
    wr(A_B, 8'h90);
    rd(A_ST, 8'h01, "pend_boundary_wr");
    rd(A_B, 8'h90, "shadow_b");
    measure(8'h00, 8'h20, 8'h40, 3, 1'b0, e0, e0 + 3075, e0 + 4096, "pwm_b_old_shadow");
    rd(A_ST, 8'h00, "pend_next_wrap");
    measure(8'h00, 8'h20, 8'h90, 3, 1'b0, e0, e0 + 4098, e0 + 4500, "pwm_b90");
    wr(A_B, 8'h10);
    rd(A_ST, 8'h01, "pend_before_force");
    wr(A_CTL, 8'h05);
    rd(A_ST, 8'h00, "pend_after_force");
    rd(A_CTL, 8'h01, "ctrl_force_reads0");
    measure(8'h00, 8'h20, 8'h10, 3, 1'b0, e0, e0 + 4506, e0 + 5200, "pwm_b_forced");

    // Inversion
    wr(A_CTL, 8'h02);
    @(posedge clk_i);
    #1;
    check("inv_disabled_led", led_o, 3'b111);
    wr(A_R, 8'h00);
    wr(A_G, 8'h00);
    wr(A_B, 8'h00);
    check("inv_disabled_led2", led_o, 3'b111);
    wr(A_CTL, 8'h03);
    e0 = cyc;
    measure(8'h00, 8'h00, 8'h00, 3, 1'b1, e0, e0 + 1, e0 + 300, "pwm_inv_duty0");

    // PRESC lowered below the running prescaler count
    wr(A_CTL, 8'h00);
    wr(A_PRE, 8'h10);
    wr(A_CTL, 8'h01);
    e0 = cyc;
    wait_edge(e0 + 10);
    wr(A_PRE, 8'h02);
    wait_edge(e0 + 14);
    rd(A_CNT, 8'h00, "presc_shrink_cnt0");
    rd(A_CNT, 8'h01, "presc_shrink_cnt1");

    // Reset mid-period with a pending update
    wr(A_CTL, 8'h00);
    wr(A_PRE, 8'h00);
    wr(A_R, 8'h80);
    rd(A_R, 8'h80, "pre_rst_read");
    wr(A_CTL, 8'h01);
    e0 = cyc;
    wait_edge(e0 + 50);
    wr(A_G, 8'h44);
    wait_edge(e0 + 100);
    check("pre_rst_led", led_o, 3'b001);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    check("midrst_led", led_o, 3'b000);
    check("midrst_rdata", io_data_o, 8'h00);
    rd(A_CTL, 8'h00, "midrst_ctrl");
    rd(A_PRE, PRST, "midrst_presc");
    rd(A_R, 8'h00, "midrst_r");
    rd(A_G, 8'h00, "midrst_g");
    rd(A_B, 8'h00, "midrst_b");
    rd(A_ST, 8'h00, "midrst_status");
    rd(A_CNT, 8'h00, "midrst_cnt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
